// File: rtl/vec_pkg.sv
// vec_pkg: shared constants and types for the vector instruction dispatcher.
// Contents: OP-V opcode, vset funct3, dispatch FSM state enum, FIFO entry struct.
package vec_pkg;

    localparam logic [6:0] OPCODE_OPV   = 7'h57;
    localparam logic [2:0] FUNCT3_VSET  = 3'b111;
    localparam int         VEC_XLEN_DEF = 32;

    typedef enum logic {
        ST_RUN,
        ST_WAIT_VL
    } disp_state_e;

    // Default-width entry; the top builds an XLEN-sized equivalent for its FIFO.
    typedef struct packed {
        logic [31:0]             inst;
        logic [VEC_XLEN_DEF-1:0] rs1;
        logic [VEC_XLEN_DEF-1:0] rs2;
    } vec_entry_t;

endpackage

// File: rtl/vec_inst_fifo.sv
// vec_inst_fifo: synchronous FIFO holding dispatched vector instructions.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   push_i        - write push_data_i (ignored while full)
//   push_data_i   - entry to store
//   pop_i         - drop the head entry (ignored while empty)
//   head_o        - current head entry
//   empty_o       - no entries stored
//   ready_o       - registered "not full", valid in the same cycle as the state it describes
module vec_inst_fifo
    import vec_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = vec_entry_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  T     push_data_i,
    input  logic pop_i,
    output T     head_o,
    output logic empty_o,
    output logic ready_o
);

    localparam int AW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic          ready_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = cnt_q == '0;
    assign ready_o = ready_q;
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i && ready_q;
    assign do_pop  = pop_i && !empty_o;
    assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q   <= cnt_d;
            ready_q <= cnt_d != (AW+1)'(DEPTH);
        end
    end

endmodule

// File: rtl/vec_inst_dispatch.sv
// vec_inst_dispatch: buffers OP-V instructions from a scalar core and issues them to a
// vector co-processor, stalling after each vset* until the new vl returns, then writing
// min(vl, VLMAX) back to the scalar rd.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   s_inst_i, s_rs1_i, s_rs2_i        - instruction and operands from the scalar core
//   s_valid_i / s_ready_o             - scalar-side handshake
//   v_inst_o, v_rs1_o, v_rs2_o        - FIFO head to the co-processor decoder
//   v_valid_o / v_ready_i             - co-processor-side handshake
//   v_vl_valid_i, v_vl_i              - new-vl response after a vset*
//   wb_valid_o, wb_rd_o, wb_data_o    - scalar rd writeback pulse
//   illegal_o                         - pulse after a non-OP-V word is dropped
//   busy_o                            - FIFO non-empty or waiting for vl
//   perf_issued_o, perf_stall_o       - saturating counters, only with VEC_DISPATCH_PERF_EN
module vec_inst_dispatch
    import vec_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int VLMAX      = 512,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     s_inst_i,
    input  logic [XLEN-1:0] s_rs1_i,
    input  logic [XLEN-1:0] s_rs2_i,
    input  logic            s_valid_i,
    output logic            s_ready_o,
    output logic [31:0]     v_inst_o,
    output logic [XLEN-1:0] v_rs1_o,
    output logic [XLEN-1:0] v_rs2_o,
    output logic            v_valid_o,
    input  logic            v_ready_i,
    input  logic            v_vl_valid_i,
    input  logic [XLEN-1:0] v_vl_i,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            illegal_o,
    output logic            busy_o
`ifdef VEC_DISPATCH_PERF_EN
    ,
    output logic [31:0]     perf_issued_o,
    output logic [31:0]     perf_stall_o
`endif
);

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } entry_t;

    disp_state_e     state_q;
    logic [4:0]      rd_q;
    logic            wb_valid_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic            illegal_q;
    entry_t          head;
    entry_t          push_data;
    logic            empty;
    logic            accept;
    logic            is_opv;
    logic            pop;
    logic [XLEN-1:0] vl_clamped;

    assign accept     = s_valid_i && s_ready_o;
    assign is_opv     = s_inst_i[6:0] == OPCODE_OPV;
    assign push_data  = '{inst: s_inst_i, rs1: s_rs1_i, rs2: s_rs2_i};
    assign v_valid_o  = !empty && state_q == ST_RUN;
    assign pop        = v_valid_o && v_ready_i;
    assign v_inst_o   = head.inst;
    assign v_rs1_o    = head.rs1;
    assign v_rs2_o    = head.rs2;
    assign vl_clamped = v_vl_i > XLEN'(VLMAX) ? XLEN'(VLMAX) : v_vl_i;
    assign wb_valid_o = wb_valid_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_data_o  = wb_data_q;
    assign illegal_o  = illegal_q;
    assign busy_o     = !empty || state_q == ST_WAIT_VL;

    vec_inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (accept && is_opv),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .empty_o     (empty),
        .ready_o     (s_ready_o)
    );

    // Issue stalls after a vset* pops until the co-processor returns vl; the
    // writeback pulse follows the response by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            illegal_q  <= 1'b0;
        end else begin
            illegal_q  <= accept && !is_opv;
            wb_valid_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (pop && head.inst[14:12] == FUNCT3_VSET) begin
                        state_q <= ST_WAIT_VL;
                        rd_q    <= head.inst[11:7];
                    end
                end
                ST_WAIT_VL: begin
                    if (v_vl_valid_i) begin
                        state_q    <= ST_RUN;
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= vl_clamped;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

`ifdef VEC_DISPATCH_PERF_EN
    logic [31:0] perf_issued_q;
    logic [31:0] perf_stall_q;
    logic        stall;

    assign stall         = state_q == ST_WAIT_VL || (v_valid_o && !v_ready_i);
    assign perf_issued_o = perf_issued_q;
    assign perf_stall_o  = perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (pop && perf_issued_q != '1) perf_issued_q <= perf_issued_q + 1'b1;
            if (stall && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 1'b1;
        end
    end
`endif

endmodule

// File: doc/vec_inst_dispatch.md
VEC_INST_DISPATCH -- requirements
Module: vec_inst_dispatch

Interface
- REQ-001: Parameter XLEN, default 32, scalar register and data width.
- REQ-002: Parameter VLMAX, default 512, maximum vector length; v_vl_i values above it are clamped.
- REQ-003: Parameter FIFO_DEPTH, default 4, power of two, depth of the instruction buffer.
- REQ-004: clk  in  1  single clock, all state on rising edge.
- REQ-005: rst  in  1  synchronous, active-high reset.
- REQ-006: s_inst_i  in  32  instruction word from the scalar core.
- REQ-007: s_rs1_i, s_rs2_i  in  XLEN  scalar source operands from the scalar core.
- REQ-008: s_valid_i  in  1 / s_ready_o  out  1  scalar-side handshake.
- REQ-009: v_inst_o  out  32 / v_rs1_o, v_rs2_o  out  XLEN  instruction and operands to the co-processor decoder.
- REQ-010: v_valid_o  out  1 / v_ready_i  in  1  co-processor-side handshake.
- REQ-011: v_vl_valid_i  in  1 / v_vl_i  in  XLEN  new-vl response from the co-processor after a vset*.
- REQ-012: wb_valid_o  out  1 / wb_rd_o  out  5 / wb_data_o  out  XLEN  scalar rd writeback.
- REQ-013: illegal_o  out  1  one-cycle pulse when a non-OP-V word is rejected.
- REQ-014: busy_o  out  1  high when the FIFO is non-empty or the state is WAIT_VL.

Function
- REQ-015: Accept on s_valid_i && s_ready_o; s_ready_o = !full, registered, with no same-cycle bypass when full.
- REQ-016: Accepted words with opcode[6:0] != 7'h57 are dropped and pulse illegal_o in the following cycle.
- REQ-017: OP-V words push {inst, rs1, rs2} into the FIFO; minimum latency from accept to v_valid_o is 1 cycle.
- REQ-018: FSM states: RUN and WAIT_VL.
- REQ-019: v_valid_o = !empty && state==RUN; v_inst_o, v_rs1_o and v_rs2_o show the FIFO head and hold stable while v_valid_o && !v_ready_i.
- REQ-020: Pop occurs on v_valid_o && v_ready_i.
- REQ-021: A popped word with funct3 == 3'b111 (vsetvli/vsetivli/vsetvl) moves the FSM RUN->WAIT_VL and latches rd = inst[11:7].
- REQ-022: In WAIT_VL, v_vl_valid_i returns the FSM to RUN.
- REQ-023: In the cycle after that v_vl_valid_i, wb_valid_o pulses with wb_rd_o = latched rd and wb_data_o = min(v_vl_i, VLMAX).
- REQ-024: The writeback pulse is issued even for rd = 0; the scalar core discards it.
- REQ-025: v_vl_valid_i in RUN is ignored.
- REQ-026: Simultaneous push and pop with the FIFO non-full: both take effect and the occupancy is unchanged.
- REQ-027: Simultaneous push and pop with the FIFO full: the push is not accepted (s_ready_o = 0).
- REQ-028: Pointers wrap modulo FIFO_DEPTH; a count of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.

Reset
- REQ-029: rst, including mid-operation and in WAIT_VL, empties the FIFO, forces RUN and discards any pending writeback.
- REQ-030: Outputs during and immediately after reset: s_ready_o = 1; v_valid_o = 0; wb_valid_o = 0; illegal_o = 0; busy_o = 0; v_inst_o, v_rs1_o, v_rs2_o, wb_rd_o, wb_data_o = 0.

Configuration
- REQ-031: Macro VEC_DISPATCH_PERF_EN defined: add outputs perf_issued_o[31:0] (pops) and perf_stall_o[31:0] (cycles in WAIT_VL or with v_valid_o && !v_ready_i).
- REQ-032: Both counters saturate at 32'hFFFFFFFF and clear on rst.
- REQ-033: Macro VEC_DISPATCH_PERF_EN undefined: the ports and counters do not exist and behaviour is otherwise identical.

Structure
- REQ-034: Shared package vec_pkg holds OPCODE_OPV = 7'h57, FUNCT3_VSET = 3'b111, the dispatch-state enum and the FIFO entry struct {inst, rs1, rs2}.
- REQ-035: One sub-module, vec_inst_fifo (parameterised synchronous FIFO), is instantiated once.

Verification
- REQ-036: Push 32'h022080d7 (vadd, rd=1), v_ready_i=1 -> v_valid_o high the next cycle, popped, FSM stays RUN, no wb_valid_o.
- REQ-037: Push 32'h01007057, rs1=32'hf, rs2=32'h1200 -> after issue FSM=WAIT_VL; v_vl_valid_i with v_vl_i=16 -> next cycle wb_valid_o=1, wb_rd_o=0, wb_data_o=16.
- REQ-038: Push 32'hc1087157 then 32'h8030f157 -> the second word is not issued until the vl response for the first; wb_rd_o=2 for each.
- REQ-039: Hold v_ready_i=0 and push 5 words -> s_ready_o falls after the 4th, the 5th is held, and v_inst_o stays stable.
- REQ-040: Push 32'h00000013 -> illegal_o pulses once and the FIFO stays empty.
- REQ-041: Assert rst while in WAIT_VL with 3 queued words -> busy_o=0 and s_ready_o=1; a late v_vl_valid_i produces no writeback.
